// File: rtl/rom_writer_if.sv
// Host-side control and chip-socket pins of the bipolar PROM programmer.
// The master drives host requests and readback; the slave is the sequencer.
interface rom_writer_if #(
  parameter int DATA_WIDTH    = 4,
  parameter int ADDRESS_WIDTH = 8
);
  logic                     address_load;
  logic [ADDRESS_WIDTH-1:0] address_value;
  logic                     write_request;
  logic [DATA_WIDTH-1:0]    write_data;
  logic [DATA_WIDTH-1:0]    data_line_in;
  logic                     busy;
  logic                     done;
  logic                     error;
  logic [3:0]               operation;
  logic [ADDRESS_WIDTH-1:0] address_line;
  logic [DATA_WIDTH-1:0]    data_line;
  logic                     prog_enable;
  logic                     chip_select_n;

  modport master (
    output address_load, address_value, write_request, write_data, data_line_in,
    input  busy, done, error, operation, address_line, data_line, prog_enable, chip_select_n
  );

  modport slave (
    input  address_load, address_value, write_request, write_data, data_line_in,
    output busy, done, error, operation, address_line, data_line, prog_enable, chip_select_n
  );
endinterface

// File: rtl/rom_writer.sv
// Fuse PROM programming sequencer: per-bit setup/pulse/recover/verify with retries.
// Optional pre-write blank check enabled by defining ROM_WRITER_BLANK_CHECK_EN.
module rom_writer #(
  parameter int DATA_WIDTH     = 4,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int SETUP_CYCLES   = 4,
  parameter int PULSE_CYCLES   = 8,
  parameter int RECOVER_CYCLES = 4,
  parameter int MAX_RETRIES    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  rom_writer_if.slave bus
);
  localparam int CMAX = (SETUP_CYCLES > PULSE_CYCLES) ?
                        ((SETUP_CYCLES > RECOVER_CYCLES) ? SETUP_CYCLES : RECOVER_CYCLES) :
                        ((PULSE_CYCLES > RECOVER_CYCLES) ? PULSE_CYCLES : RECOVER_CYCLES);
  localparam int CW = $clog2(CMAX + 1);
  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  typedef enum logic [3:0] {
    IDLE = 4'd0, SCAN = 4'd1, SETUP = 4'd2, PULSE = 4'd3, RECOVER = 4'd4,
    VERIFY = 4'd5, DONE = 4'd6, ERROR = 4'd7, BLANK = 4'd8
  } state_t;

  state_t                   state;
  logic [DATA_WIDTH-1:0]    target;
  logic [DATA_WIDTH-1:0]    data_line;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [IW-1:0]            idx;
  logic [RW-1:0]            retry;
  logic [CW-1:0]            cnt;
  logic                     prog_enable, cs_n, done, error;

  // Current bit of the target word and of the chip readback.
  logic [DATA_WIDTH-1:0] tshift, rshift;
  assign tshift = target >> idx;
  assign rshift = bus.data_line_in >> idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      target      <= '0;
      data_line   <= '0;
      addr        <= '0;
      idx         <= '0;
      retry       <= '0;
      cnt         <= '0;
      prog_enable <= 1'b0;
      cs_n        <= 1'b1;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cs_n <= 1'b1;
          if (bus.address_load) begin
            addr <= bus.address_value;
          end else if (bus.write_request) begin
            target <= bus.write_data;
            error  <= 1'b0;
            idx    <= '0;
            retry  <= '0;
`ifdef ROM_WRITER_BLANK_CHECK_EN
            cs_n   <= 1'b0;
            cnt    <= CW'(SETUP_CYCLES - 1);
            state  <= BLANK;
`else
            state  <= SCAN;
`endif
          end
        end
`ifdef ROM_WRITER_BLANK_CHECK_EN
        BLANK: begin
          if (cnt == '0) begin
            // A blown fuse where the word wants 0 can never be undone.
            if (|(bus.data_line_in & ~target)) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= ERROR;
            end else begin
              state <= SCAN;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        SCAN: begin
          if (idx >= IW'(DATA_WIDTH)) begin
            done  <= 1'b1;
            addr  <= addr + 1'b1;
            state <= DONE;
          end else if (tshift[0]) begin
            retry     <= '0;
            cs_n      <= 1'b0;
            data_line <= ONE << idx;
            cnt       <= CW'(SETUP_CYCLES - 1);
            state     <= SETUP;
          end else if (idx == IW'(DATA_WIDTH - 1)) begin
            done  <= 1'b1;
            addr  <= addr + 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            prog_enable <= 1'b1;
            cnt         <= CW'(PULSE_CYCLES - 1);
            state       <= PULSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            prog_enable <= 1'b0;
            data_line   <= '0;
            cnt         <= CW'(RECOVER_CYCLES - 1);
            state       <= RECOVER;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RECOVER: begin
          if (cnt == '0) state <= VERIFY;
          else           cnt   <= cnt - 1'b1;
        end
        VERIFY: begin
          if (rshift[0]) begin
            idx   <= idx + 1'b1;
            state <= SCAN;
          end else if (retry < RW'(MAX_RETRIES)) begin
            retry     <= retry + 1'b1;
            data_line <= ONE << idx;
            cnt       <= CW'(SETUP_CYCLES - 1);
            state     <= SETUP;
          end else begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= ERROR;
          end
        end
        DONE, ERROR: begin
          cs_n  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy          = (state != IDLE);
  assign bus.operation     = state;
  assign bus.done          = done;
  assign bus.error         = error;
  assign bus.address_line  = addr;
  assign bus.data_line     = data_line;
  assign bus.prog_enable   = prog_enable;
  assign bus.chip_select_n = cs_n;
endmodule

// File: tb/tb_rom_writer.sv
// Directed bench for rom_writer with a fuse-array chip model and pulse monitor.
module tb_rom_writer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rom_writer_if #(.DATA_WIDTH(4), .ADDRESS_WIDTH(8)) bus ();

  rom_writer #(
    .DATA_WIDTH(4), .ADDRESS_WIDTH(8), .SETUP_CYCLES(4),
    .PULSE_CYCLES(8), .RECOVER_CYCLES(4), .MAX_RETRIES(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  // Chip model: a pulsed bit blows unless marked stuck; preset models factory-blown fuses.
  logic [3:0] fuse   [256];
  logic [3:0] preset [256];
  logic [3:0] stuck;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) fuse[i] <= 4'h0;
    end else if (bus.prog_enable) begin
      fuse[bus.address_line] <= fuse[bus.address_line] | (bus.data_line & ~stuck);
    end
  end

  assign bus.data_line_in = fuse[bus.address_line] | preset[bus.address_line];

  int         pulses = 0, pe_cyc = 0, dones = 0, bad_pe = 0;
  logic       pe_q = 1'b0;
  logic [3:0] pdata [8];

  always @(negedge clk) begin
    pe_q <= bus.prog_enable;
    if (bus.prog_enable) begin
      pe_cyc <= pe_cyc + 1;
      if (!pe_q) begin
        pdata[pulses & 7] <= bus.data_line;
        pulses <= pulses + 1;
      end
      if (bus.operation != 4'd3) bad_pe <= bad_pe + 1;
    end
    if (bus.done) dones <= dones + 1;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  int   r_busy, r_pulses, r_pecyc, p0, d0;
  logic [3:0] r_op;
  logic r_err;

  task automatic load_addr(input logic [7:0] a);
    @(negedge clk);
    bus.address_load = 1'b1; bus.address_value = a;
    @(negedge clk);
    bus.address_load = 1'b0;
    chk("addr_load", 32'(bus.address_line), 32'(a));
  endtask

  task automatic do_write(input logic [3:0] d, input bit inject);
    bit seen;
    @(negedge clk);
    p0 = pulses; d0 = dones;
    r_pecyc = pe_cyc;
    bus.write_data = d; bus.write_request = 1'b1;
    @(negedge clk);
    bus.write_request = 1'b0;
    r_busy = 0; seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      if (bus.busy) r_busy++;
      if (inject && r_busy == 6) begin
        bus.address_load = 1'b1; bus.address_value = 8'h33;
        bus.write_request = 1'b1; bus.write_data = 4'hF;
      end else begin
        bus.address_load = 1'b0; bus.write_request = 1'b0;
      end
      if (bus.done) begin
        seen = 1'b1; r_op = bus.operation; r_err = bus.error;
      end else begin
        @(negedge clk);
      end
    end
    bus.address_load = 1'b0; bus.write_request = 1'b0;
    if (!seen) chk("done_timeout", 32'(0), 32'(1));
    @(negedge clk);
    r_pulses = pulses - p0;
    r_pecyc  = pe_cyc - r_pecyc;
    chk("idle_after", 32'(bus.busy), 32'(0));
    chk("one_done", 32'(dones - d0), 32'(1));
  endtask

  initial begin
    bool_init();
    // 1. reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_err",  32'(bus.error), 32'(0));
    chk("rst_op",   32'(bus.operation), 32'(0));
    chk("rst_addr", 32'(bus.address_line), 32'(0));
    chk("rst_data", 32'(bus.data_line), 32'(0));
    chk("rst_pe",   32'(bus.prog_enable), 32'(0));
    chk("rst_csn",  32'(bus.chip_select_n), 32'(1));
    reset_n = 1'b1;

    // 2. good word 0101 at 0x10
    load_addr(8'h10);
    do_write(4'b0101, 1'b0);
    chk("good_pulses", 32'(r_pulses), 32'(2));
    chk("good_pecyc",  32'(r_pecyc), 32'(16));
    chk("good_sel0",   32'(pdata[p0 & 7]), 32'(4'b0001));
    chk("good_sel1",   32'(pdata[(p0 + 1) & 7]), 32'(4'b0100));
    chk("good_busy",   32'(r_busy), 32'(39));
    chk("good_op",     32'(r_op), 32'(6));
    chk("good_err",    32'(r_err), 32'(0));
    chk("good_addr",   32'(bus.address_line), 32'(8'h11));
    chk("good_fuse",   32'(fuse[8'h10]), 32'(4'b0101));

    // 3. all-zero word
    do_write(4'b0000, 1'b0);
    chk("zero_pulses", 32'(r_pulses), 32'(0));
    chk("zero_busy",   32'(r_busy), 32'(5));
    chk("zero_addr",   32'(bus.address_line), 32'(8'h12));

    // 4. stuck bit 1
    stuck = 4'b0010;
    do_write(4'b0010, 1'b0);
    chk("stuck_pulses", 32'(r_pulses), 32'(4));
    chk("stuck_pecyc",  32'(r_pecyc), 32'(32));
    chk("stuck_op",     32'(r_op), 32'(7));
    chk("stuck_err",    32'(r_err), 32'(1));
    chk("stuck_busy",   32'(r_busy), 32'(71));
    chk("stuck_addr",   32'(bus.address_line), 32'(8'h12));
    chk("stuck_sticky", 32'(bus.error), 32'(1));
    stuck = 4'b0000;
    do_write(4'b0000, 1'b0);
    chk("err_cleared", 32'(r_err), 32'(0));
    chk("clr_addr",    32'(bus.address_line), 32'(8'h13));

    // 5. wrap, with host inputs injected while busy
    load_addr(8'hFF);
    do_write(4'b1000, 1'b1);
    chk("wrap_pulses", 32'(r_pulses), 32'(1));
    chk("wrap_sel",    32'(pdata[p0 & 7]), 32'(4'b1000));
    chk("wrap_busy",   32'(r_busy), 32'(23));
    chk("wrap_addr",   32'(bus.address_line), 32'(8'h00));
    chk("wrap_fuse",   32'(fuse[8'hFF]), 32'(4'b1000));
    chk("wrap_err",    32'(r_err), 32'(0));

    // 6. pre-blown fuse at 0x40
    load_addr(8'h40);
    do_write(4'b0001, 1'b0);
`ifdef ROM_WRITER_BLANK_CHECK_EN
    chk("blank_pulses", 32'(r_pulses), 32'(0));
    chk("blank_err",    32'(r_err), 32'(1));
    chk("blank_op",     32'(r_op), 32'(7));
    chk("blank_busy",   32'(r_busy), 32'(5));
    chk("blank_addr",   32'(bus.address_line), 32'(8'h40));
`else
    chk("blank_pulses", 32'(r_pulses), 32'(1));
    chk("blank_err",    32'(r_err), 32'(0));
    chk("blank_op",     32'(r_op), 32'(6));
    chk("blank_busy",   32'(r_busy), 32'(22));
    chk("blank_addr",   32'(bus.address_line), 32'(8'h41));
`endif
    chk("pe_only_pulse", 32'(bad_pe), 32'(0));

    // 1b. reset asserted in the middle of a pulse
    load_addr(8'h80);
    @(negedge clk);
    bus.write_data = 4'b0001; bus.write_request = 1'b1;
    @(negedge clk);
    bus.write_request = 1'b0;
    for (int i = 0; i < 100 && !bus.prog_enable; i++) @(negedge clk);
    chk("mid_pe_high", 32'(bus.prog_enable), 32'(1));
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_pe_low", 32'(bus.prog_enable), 32'(0));
    chk("mid_csn",    32'(bus.chip_select_n), 32'(1));
    chk("mid_busy",   32'(bus.busy), 32'(0));
    chk("mid_addr",   32'(bus.address_line), 32'(0));
    chk("mid_data",   32'(bus.data_line), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  task automatic bool_init();
    stuck = 4'b0000;
    bus.address_load = 1'b0; bus.address_value = 8'h00;
    bus.write_request = 1'b0; bus.write_data = 4'h0;
    for (int i = 0; i < 256; i++) preset[i] = 4'h0;
    preset[8'h40] = 4'b0100;
  endtask
endmodule
